// File: rtl/dmem_line_ctrl.sv
// Line-granular main-memory model: one 256-bit line read or write at a time, acknowledged LATENCY cycles after acceptance.
// Optional build macro DMEM_RANGE_CHECK_EN adds err_o and rejects addresses beyond the 16 KB array.
//
// state | meaning
// IDLE  | waiting for enable_i; captures index, data and direction on acceptance
// WAIT  | counting down; array access happens on the edge where the counter is 0
// ACK   | ack_o high for one cycle; request inputs ignored; always returns to IDLE

module dmem_line_ctrl #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   input  logic         enable_i,
   input  logic         write_i,
   output logic         ack_o,
   output logic [255:0] data_o
`ifdef DMEM_RANGE_CHECK_EN
   ,
   output logic         err_o
`endif
);

   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q;
   logic [255:0]       wdata_q;
   logic               wr_q;
   logic               oor_q;
   logic               oor;
   logic               capture;
   logic               access;
   logic               unused_addr_bits;

   logic [255:0]       memory [0:DEPTH-1];

`ifdef DMEM_RANGE_CHECK_EN
   assign oor              = |addr_i[31:5+IDX_W];
   assign unused_addr_bits = ^addr_i[4:0];
`else
   // Upper address bits alias into the array when range checking is off.
   assign oor              = 1'b0;
   assign unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // LATENCY=1 loads a zero count, so the access lands on the very next edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               capture = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 8'd0) begin
               access  = 1'b1;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
         data_o  <= '0;
      end else begin
         if (capture) begin
            idx_q   <= addr_i[5 +: IDX_W];
            wdata_q <= data_i;
            wr_q    <= write_i;
            oor_q   <= oor;
         end
         if (access && !wr_q) begin
            data_o <= oor_q ? '0 : memory[idx_q];
         end
      end
   end

   // Array is deliberately left out of reset so bench preloads survive it.
   always_ff @(posedge clk_i) begin
      if (access && wr_q && !oor_q) begin
         memory[idx_q] <= wdata_q;
      end
   end

   assign ack_o = (state_q == ACK);

`ifdef DMEM_RANGE_CHECK_EN
   assign err_o = ack_o & oor_q;
`endif

endmodule
